// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared constants and types for the AES cores and their serial front-end.
//   BLOCK_W  : AES block width in bits (128)
//   CNT_W    : width of the serial bit counter (covers 0..KEY_W-1 for NK<=8)
//   state_t  : serial-port FSM states
//   key_w(nk): key width in bits for an NK-word key
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int BLOCK_W = 128;
    localparam int CNT_W   = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_DATA,
        ST_RX_KEY,
        ST_START,
        ST_WAIT_CORE,
        ST_TX,
        ST_FINISH
    } state_t;

    function automatic int key_w(input int nk);
        return nk * 32;
    endfunction

endpackage

// File: rtl/aes_shift_rx.sv
// -----------------------------------------------------------------------------
// aes_shift_rx
// LSB-first deserializer: when we_i is high, the bit at index idx_i of data_o
// is overwritten with bit_i. Every other bit holds its value, so the captured
// word stays stable after reception completes.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears data_o)
//   we_i      : write enable for this cycle
//   idx_i     : bit index to write
//   bit_i     : serial input bit
//   data_o    : assembled word (W bits)
// -----------------------------------------------------------------------------
module aes_shift_rx
    import aes_pkg::*;
#(
    parameter int W = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [CNT_W-1:0] idx_i,
    input  logic             bit_i,
    output logic [W-1:0]     data_o
);

    // One flop per bit with its own decoded enable.
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        logic bit_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                bit_q <= 1'b0;
            end else if (we_i && (idx_i == CNT_W'(gi))) begin
                bit_q <= bit_i;
            end
        end

        assign data_o[gi] = bit_q;
    end

endmodule

// File: rtl/aes_serial_port.sv
// -----------------------------------------------------------------------------
// aes_serial_port
// Serial slave front-end for an AES Cipher/InvCipher core. Receives a 128-bit
// data block followed by an NK*32-bit key on mosi (LSB-first, framed by cs_n
// low). It then pulses core_start, waits for core_done and shifts the 128-bit
// result out on miso (LSB-first) with miso_vld high.
//
// Optional feature macro: AES_SPI_PARITY_EN
//   defined   : one extra TX bit after the result carries its even parity
//   undefined : TX is exactly 128 bits
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   cs_n, mosi   : frame select (active low) and serial input
//   miso         : serial result bit (0 when idle)
//   miso_vld     : miso carries a result bit
//   core_start   : one-cycle launch pulse to the core
//   core_data    : received data block (stable until the next frame)
//   core_key     : received key (stable until the next frame)
//   core_done    : one-cycle completion pulse from the core
//   core_result  : core output, valid with core_done
//   busy         : FSM not in IDLE
// -----------------------------------------------------------------------------
module aes_serial_port
    import aes_pkg::*;
#(
    parameter int NK = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cs_n,
    input  logic                    mosi,
    output logic                    miso,
    output logic                    miso_vld,
    output logic                    core_start,
    output logic [BLOCK_W-1:0]      core_data,
    output logic [key_w(NK)-1:0]    core_key,
    input  logic                    core_done,
    input  logic [BLOCK_W-1:0]      core_result,
    output logic                    busy
);

    localparam int KEY_W = key_w(NK);

`ifdef AES_SPI_PARITY_EN
    localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(BLOCK_W);
`else
    localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(BLOCK_W - 1);
`endif

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BLOCK_W-1:0]   shreg_q;
    logic                 miso_q;
    logic                 vld_q;
    logic                 start_q;
    logic                 abort_q;
`ifdef AES_SPI_PARITY_EN
    logic                 par_q;
`endif

    logic                 data_we;
    logic [CNT_W-1:0]     data_idx;
    logic                 key_we;

    // The first data bit is captured in IDLE on the cycle cs_n is first seen
    // low, so the data index is forced to 0 there.
    assign data_we  = !cs_n && ((state_q == ST_IDLE) || (state_q == ST_RX_DATA));
    assign data_idx = (state_q == ST_IDLE) ? '0 : cnt_q;
    assign key_we   = !cs_n && (state_q == ST_RX_KEY);

    aes_shift_rx #(.W(BLOCK_W)) u_rx_data (
        .clk    (clk),
        .rst    (rst),
        .we_i   (data_we),
        .idx_i  (data_idx),
        .bit_i  (mosi),
        .data_o (core_data)
    );

    aes_shift_rx #(.W(KEY_W)) u_rx_key (
        .clk    (clk),
        .rst    (rst),
        .we_i   (key_we),
        .idx_i  (cnt_q),
        .bit_i  (mosi),
        .data_o (core_key)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            miso_q  <= 1'b0;
            vld_q   <= 1'b0;
            start_q <= 1'b0;
            abort_q <= 1'b0;
`ifdef AES_SPI_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    miso_q  <= 1'b0;
                    vld_q   <= 1'b0;
                    abort_q <= 1'b0;
                    if (!cs_n) begin
                        cnt_q   <= CNT_W'(1);
                        state_q <= ST_RX_DATA;
                    end
                end
                ST_RX_DATA: begin
                    if (cs_n) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == CNT_W'(BLOCK_W - 1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_RX_KEY;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RX_KEY: begin
                    if (cs_n) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == CNT_W'(KEY_W - 1)) begin
                        cnt_q   <= '0;
                        state_q <= ST_START;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_START: begin
                    start_q <= 1'b1;
                    state_q <= ST_WAIT_CORE;
                end
                ST_WAIT_CORE: begin
                    // A deselect here cannot cancel the core, so remember it
                    // and swallow the result when it arrives.
                    if (cs_n) begin
                        abort_q <= 1'b1;
                    end
                    if (core_done) begin
                        if (abort_q || cs_n) begin
                            abort_q <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            // Bit 0 goes straight to miso; the rest queue up.
                            miso_q  <= core_result[0];
                            vld_q   <= 1'b1;
                            shreg_q <= core_result >> 1;
                            cnt_q   <= '0;
`ifdef AES_SPI_PARITY_EN
                            par_q   <= ^core_result;
`endif
                            state_q <= ST_TX;
                        end
                    end
                end
                ST_TX: begin
                    // cnt_q is the index of the bit currently on miso.
                    if (cs_n) begin
                        miso_q  <= 1'b0;
                        vld_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == TX_LAST) begin
                        miso_q  <= 1'b0;
                        vld_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_FINISH;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        shreg_q <= shreg_q >> 1;
`ifdef AES_SPI_PARITY_EN
                        if (cnt_q == CNT_W'(BLOCK_W - 1)) begin
                            miso_q <= par_q;
                        end else begin
                            miso_q <= shreg_q[0];
                        end
`else
                        miso_q  <= shreg_q[0];
`endif
                    end
                end
                ST_FINISH: begin
                    miso_q <= 1'b0;
                    vld_q  <= 1'b0;
                    if (cs_n) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign miso       = miso_q;
    assign miso_vld   = vld_q;
    assign core_start = start_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aes_serial_port.sv
// -----------------------------------------------------------------------------
// tb_aes_serial_port
// Directed bench for aes_serial_port: one NK=8 and one NK=4 instance, each
// with a small core model that answers core_start with core_done 20 cycles
// later. Inputs change on negedge; outputs are sampled on negedge.
// Honours AES_SPI_PARITY_EN for the extra TX bit.
// -----------------------------------------------------------------------------
module tb_aes_serial_port;

    localparam logic [127:0] DATA = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY4 = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] RES8 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] RES4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, mosi, cs8_n, cs4_n, sel4;

    logic         miso8, vld8, start8, done8, busy8;
    logic [127:0] data8, res8;
    logic [255:0] key8;
    logic         miso4, vld4, start4, done4, busy4;
    logic [127:0] data4, res4;
    logic [127:0] key4;

    aes_serial_port #(.NK(8)) dut8 (
        .clk(clk), .rst(rst), .cs_n(cs8_n), .mosi(mosi),
        .miso(miso8), .miso_vld(vld8), .core_start(start8),
        .core_data(data8), .core_key(key8), .core_done(done8),
        .core_result(res8), .busy(busy8)
    );

    aes_serial_port #(.NK(4)) dut4 (
        .clk(clk), .rst(rst), .cs_n(cs4_n), .mosi(mosi),
        .miso(miso4), .miso_vld(vld4), .core_start(start4),
        .core_data(data4), .core_key(key4), .core_done(done4),
        .core_result(res4), .busy(busy4)
    );

    // Core models: done pulses 20 cycles after start is sampled.
    int dly8 = 0, dly4 = 0;
    always @(posedge clk) begin
        done8 <= 1'b0;
        if (dly8 > 0) begin
            dly8 <= dly8 - 1;
            if (dly8 == 1) done8 <= 1'b1;
        end else if (start8) begin
            dly8 <= 20;
        end
    end
    always @(posedge clk) begin
        done4 <= 1'b0;
        if (dly4 > 0) begin
            dly4 <= dly4 - 1;
            if (dly4 == 1) done4 <= 1'b1;
        end else if (start4) begin
            dly4 <= 20;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Views of whichever instance is under test.
    logic         v_miso, v_vld, v_start, v_done, v_busy;
    logic [127:0] v_data;
    logic [255:0] v_key;
    assign v_miso  = sel4 ? miso4  : miso8;
    assign v_vld   = sel4 ? vld4   : vld8;
    assign v_start = sel4 ? start4 : start8;
    assign v_done  = sel4 ? done4  : done8;
    assign v_busy  = sel4 ? busy4  : busy8;
    assign v_data  = sel4 ? data4  : data8;
    assign v_key   = sel4 ? {128'b0, key4} : key8;

    int errors = 0;
    int checks = 0;
    int e0 = 0;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic set_cs(input logic v);
        if (sel4) cs4_n = v; else cs8_n = v;
    endtask

    // Drive n bits LSB-first; e0 is the cycle stamp of the first sample edge.
    task automatic send(input logic [383:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            set_cs(1'b0);
            mosi = bits[i];
            if (i == 1) e0 = cyc;
        end
        @(negedge clk);
        mosi = 1'b0;
    endtask

    // Returns 1 if v_start is seen within the budget; leaves us on that negedge.
    task automatic wait_start(output bit found);
        found = 0;
        if (v_start) found = 1;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            if (v_start) found = 1;
        end
    endtask

    task automatic wait_vld(output bit found);
        found = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            if (v_vld) found = 1;
        end
    endtask

    task automatic run_txn(input string nm, input int kw, input logic [255:0] key,
                           input logic [127:0] res, input logic exp_par);
        logic [383:0] bits;
        logic [127:0] got;
        bit           found;
        int           dc, nv;
        if (sel4) res4 = res; else res8 = res;
        bits = '0;
        bits[127:0]   = DATA;
        bits[383:128] = key;
        send(bits, 128 + kw);
        wait_start(found);
        check_val({nm, " start_seen"}, 256'(found), 256'(1));
        // core_start is high in the cycle after edge 128+KEY_W, i.e. the core
        // samples it on edge 128+KEY_W+1.
        check_val({nm, " start_cycle"}, 256'(cyc - e0), 256'(128 + kw));
        check_val({nm, " core_data"}, 256'(v_data), 256'(DATA));
        check_val({nm, " core_key"}, v_key, key);
        found = 0;
        dc = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            if (v_done) begin
                found = 1;
                dc = cyc;
            end
        end
        wait_vld(found);
        check_val({nm, " done_to_miso"}, 256'(cyc - dc), 256'(1));
        got = '0;
        nv = 0;
        for (int i = 0; i < 128; i++) begin
            if (i > 0) @(negedge clk);
            got[i] = v_miso;
            if (v_vld) nv++;
        end
        check_val({nm, " result"}, 256'(got), 256'(res));
        check_val({nm, " vld_count"}, 256'(nv), 256'(128));
`ifdef AES_SPI_PARITY_EN
        @(negedge clk);
        check_val({nm, " parity_vld"}, 256'(v_vld), 256'(1));
        check_val({nm, " parity_bit"}, 256'(v_miso), 256'(exp_par));
`else
        if (exp_par === 1'bx) $display("unexpected parity argument");
`endif
        @(negedge clk);
        check_val({nm, " tx_end_vld"}, 256'(v_vld), 256'(0));
        set_cs(1'b1);
        @(negedge clk);
        check_val({nm, " busy_after"}, 256'(v_busy), 256'(0));
    endtask

    initial begin
        logic [383:0] bits;
        bit           found;
        int           n;

        rst = 1'b1; cs8_n = 1'b1; cs4_n = 1'b1; mosi = 1'b0; sel4 = 1'b0;
        res8 = '0; res4 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("reset miso", 256'(miso8), 256'(0));
        check_val("reset miso_vld", 256'(vld8), 256'(0));
        check_val("reset core_start", 256'(start8), 256'(0));
        check_val("reset busy", 256'(busy8), 256'(0));
        check_val("reset core_data", 256'(data8), 256'(0));
        check_val("reset core_key", key8, 256'(0));

        // Full NK=8 transaction.
        run_txn("nk8", 256, KEY8, RES8, ^RES8);

        // Full NK=4 transaction.
        sel4 = 1'b1;
        run_txn("nk4", 128, KEY4, RES4, ^RES4);
        sel4 = 1'b0;

        // Abort during reception after 200 bits.
        bits = '0;
        bits[127:0]   = DATA;
        bits[383:128] = KEY8;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cs8_n = 1'b0;
            mosi  = bits[i];
        end
        @(negedge clk);
        cs8_n = 1'b1;
        @(negedge clk);
        check_val("rx_abort busy", 256'(busy8), 256'(0));
        n = 0;
        for (int k = 0; k < 250; k++) begin
            @(negedge clk);
            if (start8) n++;
        end
        check_val("rx_abort no_start", 256'(n), 256'(0));
        run_txn("after_abort", 256, KEY8, RES8, ^RES8);

        // Deselect while waiting for the core.
        bits = '0;
        bits[127:0]   = DATA;
        bits[383:128] = KEY8;
        send(bits, 384);
        wait_start(found);
        check_val("wait_abort start_seen", 256'(found), 256'(1));
        @(negedge clk);
        cs8_n = 1'b1;
        n = 0;
        found = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (vld8) n++;
            if (done8) found = 1;
        end
        check_val("wait_abort done_seen", 256'(found), 256'(1));
        check_val("wait_abort vld_count", 256'(n), 256'(0));
        check_val("wait_abort busy", 256'(busy8), 256'(0));

        // Reset pulse while bit 60 of the result is on miso.
        send(bits, 384);
        wait_vld(found);
        check_val("rst_tx vld_seen", 256'(found), 256'(1));
        repeat (60) @(negedge clk);
        check_val("rst_tx bit60", 256'(miso8), 256'(RES8[60]));
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_tx miso", 256'(miso8), 256'(0));
        check_val("rst_tx miso_vld", 256'(vld8), 256'(0));
        check_val("rst_tx busy", 256'(busy8), 256'(0));
        check_val("rst_tx core_data", 256'(data8), 256'(0));
        check_val("rst_tx core_key", key8, 256'(0));
        rst = 1'b0;
        cs8_n = 1'b1;
        repeat (3) @(negedge clk);

`ifdef AES_SPI_PARITY_EN
        run_txn("par_ones", 256, KEY8, {128{1'b1}}, 1'b0);
        run_txn("par_one", 256, KEY8, 128'h1, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
